wb_intercon: RTL and testbench

WB_INTERCON -- requirements
Module: wb_intercon

---
 rtl/wb_intercon.sv | 208 ++++++++++++++++++++
 tb/tb_wb_intercon.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wb_intercon.sv
// Shared-bus Wishbone interconnect: round-robin master arbiter, MSB address decode, error on unmapped access.
// Optional watchdog enabled by defining WB_INTERCON_TIMEOUT_EN.
module wb_intercon #(
  parameter int NM       = 2,
  parameter int NS       = 6,
  parameter int S_ADDR_W = 3,
  parameter logic [NS*S_ADDR_W-1:0] S_ADDRS = {3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000},
  parameter int TIMEOUT  = 255
) (
  input  logic             sys_clk,
  input  logic             sys_rst,

  input  logic [NM*32-1:0] m_adr_i,
  input  logic [NM*32-1:0] m_dat_i,
  input  logic [NM*4-1:0]  m_sel_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  output logic [NM*32-1:0] m_dat_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,

  output logic [NS*32-1:0] s_adr_o,
  output logic [NS*32-1:0] s_dat_o,
  output logic [NS*4-1:0]  s_sel_o,
  output logic [NS-1:0]    s_we_o,
  output logic [NS-1:0]    s_cyc_o,
  output logic [NS-1:0]    s_stb_o,
  input  logic [NS*32-1:0] s_dat_i,
  input  logic [NS-1:0]    s_ack_i,
  input  logic [NS-1:0]    s_err_i,

  output logic [NM-1:0]    gnt_o
);

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t        state;
  logic [NM-1:0] gnt;
  logic [PW-1:0] ptr;
  logic          err_q;
  logic          err_hold;
  logic [31:0]   err_adr;
  logic          wd_err;

  // Granted master's bus, all zero when nobody owns the bus
  logic [31:0]   g_adr, g_dat;
  logic [3:0]    g_sel;
  logic          g_we, g_cyc, g_stb;
  logic [PW-1:0] g_idx;

  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_idx = '0;
    for (int unsigned j = 0; j < NM; j++) begin
      if (gnt[j]) begin
        g_adr = m_adr_i[j*32 +: 32];
        g_dat = m_dat_i[j*32 +: 32];
        g_sel = m_sel_i[j*4 +: 4];
        g_we  = m_we_i[j];
        g_cyc = m_cyc_i[j];
        g_stb = m_stb_i[j];
        g_idx = PW'(j);
      end
    end
  end

  // Round-robin pick: scan ptr..NM-1 first, then 0..ptr-1
  logic [PW-1:0] pick;
  logic          pick_ok;

  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int unsigned j = 0; j < NM; j++) begin
      if (!pick_ok && m_cyc_i[j] && (PW'(j) >= ptr)) begin
        pick    = PW'(j);
        pick_ok = 1'b1;
      end
    end
    for (int unsigned j = 0; j < NM; j++) begin
      if (!pick_ok && m_cyc_i[j] && (PW'(j) < ptr)) begin
        pick    = PW'(j);
        pick_ok = 1'b1;
      end
    end
  end

  logic [PW-1:0] ptr_next;
  assign ptr_next = (g_idx == PW'(NM-1)) ? '0 : g_idx + PW'(1);

  // Address decode, lowest matching slave wins
  logic [S_ADDR_W-1:0] code;
  logic                hit;
  logic [SW-1:0]       sidx;

  assign code = g_adr[31 -: S_ADDR_W];

  always_comb begin
    hit  = 1'b0;
    sidx = '0;
    for (int unsigned k = 0; k < NS; k++) begin
      if (!hit && (code == S_ADDRS[k*S_ADDR_W +: S_ADDR_W])) begin
        hit  = 1'b1;
        sidx = SW'(k);
      end
    end
  end

  logic        ack_sel, err_sel;
  logic [31:0] dat_sel;

  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    ack_sel = 1'b0;
    err_sel = 1'b0;
    dat_sel = '0;
    for (int unsigned k = 0; k < NS; k++) begin
      if (hit && (sidx == SW'(k))) begin
        s_cyc_o[k] = g_cyc & ~wd_err;
        s_stb_o[k] = g_stb & ~wd_err;
        ack_sel    = s_ack_i[k];
        err_sel    = s_err_i[k];
        dat_sel    = s_dat_i[k*32 +: 32];
      end
    end
  end

  assign s_adr_o = {NS{g_adr}};
  assign s_dat_o = {NS{g_dat}};
  assign s_sel_o = {NS{g_sel}};
  assign s_we_o  = {NS{g_we}};

  assign m_dat_o = {NM{dat_sel}};
  assign m_ack_o = gnt & {NM{ack_sel}};
  assign m_err_o = gnt & {NM{err_sel | err_q | wd_err}};
  assign gnt_o   = gnt;

  // A repeated unmapped strobe to the same address is reported only once
  logic unmapped_req, err_blocked;
  assign unmapped_req = g_cyc & g_stb & ~hit;
  assign err_blocked  = err_hold & (g_adr == err_adr);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      gnt      <= '0;
      ptr      <= '0;
      err_q    <= 1'b0;
      err_hold <= 1'b0;
      err_adr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_ok) begin
            gnt   <= NM'(1'b1) << pick;
            state <= OWNED;
          end
        end
        OWNED: begin
          if (!g_cyc) begin
            gnt   <= '0;
            ptr   <= ptr_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      err_q <= unmapped_req & ~err_blocked;
      if (unmapped_req && !err_blocked) begin
        err_hold <= 1'b1;
        err_adr  <= g_adr;
      end else if (!g_stb || (g_adr != err_adr)) begin
        err_hold <= 1'b0;
      end
    end
  end

`ifdef WB_INTERCON_TIMEOUT_EN
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);
  logic [7:0] wd_cnt;

  assign wd_err = (wd_cnt == WD_LIMIT);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wd_cnt <= '0;
    end else if (wd_err || !(g_cyc && g_stb && hit) || ack_sel || err_sel) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end
`else
  assign wd_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_intercon.sv
// Directed bench for wb_intercon: single read, round-robin handover, unmapped error,
// watchdog (with and without WB_INTERCON_TIMEOUT_EN) and mid-transfer reset.
module tb_wb_intercon;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   m_adr_i, m_dat_i;
  logic [7:0]    m_sel_i;
  logic [1:0]    m_we_i, m_cyc_i, m_stb_i;
  logic [63:0]   m_dat_o;
  logic [1:0]    m_ack_o, m_err_o, gnt_o;
  logic [191:0]  s_adr_o, s_dat_o;
  logic [23:0]   s_sel_o;
  logic [5:0]    s_we_o, s_cyc_o, s_stb_o;
  logic [191:0]  s_dat_i;
  logic [5:0]    s_ack_i, s_err_i;
  logic          ack0;

  int checks = 0;
  int failures = 0;

  wb_intercon #(.TIMEOUT(16)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  // Slave 0 is a one-cycle bram returning DEADBEEF; every other slave never responds
  always @(posedge clk) ack0 <= rst ? 1'b0 : (s_cyc_o[0] & s_stb_o[0] & ~ack0);
  assign s_ack_i = {5'b0, ack0};
  assign s_err_i = '0;
  assign s_dat_i = {32'h5555_5555, 32'h4444_4444, 32'h3333_3333,
                    32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_m(input int j, input logic cyc, input logic stb,
                       input logic we, input logic [31:0] adr);
    m_cyc_i[j]         = cyc;
    m_stb_i[j]         = stb;
    m_we_i[j]          = we;
    m_adr_i[j*32 +: 32] = adr;
  endtask

  int seen_err;

  initial begin
    rst = 1'b1;
    m_adr_i = '0; m_dat_i = {32'hCAFE_0001, 32'h1234_5678}; m_sel_i = 8'hFF;
    m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;

    // Reset state
    tick(); tick(); #1;
    check("rst_gnt", gnt_o, 0);
    check("rst_cyc", s_cyc_o, 0);
    check("rst_stb", s_stb_o, 0);
    check("rst_ack", m_ack_o, 0);
    check("rst_err", m_err_o, 0);
    rst = 1'b0;

    // m0 single read of 0x10 from slave 0
    tick(); set_m(0, 1, 1, 0, 32'h0000_0010); #1;
    check("rd_c0_stb", s_stb_o, 0);
    tick(); #1;
    check("rd_c1_stb", s_stb_o, 6'b000001);
    check("rd_c1_gnt", gnt_o, 2'b01);
    check("rd_c1_ack", m_ack_o, 0);
    tick(); #1;
    check("rd_c2_ack", m_ack_o, 2'b01);
    check("rd_c2_dat", m_dat_o[31:0], 32'hDEAD_BEEF);
    tick(); set_m(0, 0, 0, 0, 32'h0); #1;
    tick();

    // Simultaneous requests straight after reset: m0 then m1
    rst = 1'b1;
    tick(); rst = 1'b0;
    set_m(0, 1, 1, 0, 32'h0000_0010);
    set_m(1, 1, 1, 0, 32'h0000_0020);
    tick(); #1;
    check("rr_c1_gnt", gnt_o, 2'b01);
    tick(); #1;
    check("rr_c2_ack", m_ack_o, 2'b01);
    set_m(0, 0, 0, 0, 32'h0);
    tick(); #1;
    check("rr_c3_idle", gnt_o, 2'b00);
    tick(); #1;
    check("rr_c4_gnt", gnt_o, 2'b10);
    check("rr_c4_stb", s_stb_o, 6'b000001);
    tick(); #1;
    check("rr_c5_ack", m_ack_o, 2'b10);
    check("rr_c5_dat", m_dat_o[63:32], 32'hDEAD_BEEF);
    set_m(1, 0, 0, 0, 32'h0);
    tick();

    // m1 accesses unmapped 0xE0000000
    set_m(1, 1, 1, 0, 32'hE000_0000);
    tick(); #1;
    check("um_c1_gnt", gnt_o, 2'b10);
    check("um_c1_err", m_err_o, 0);
    check("um_c1_cyc", s_cyc_o, 0);
    tick(); #1;
    check("um_c2_err", m_err_o, 2'b10);
    check("um_c2_cyc", s_cyc_o, 0);
    tick(); #1;
    check("um_c3_err", m_err_o, 0);
    m_stb_i[1] = 1'b0;
    tick(); m_stb_i[1] = 1'b1; #1;
    check("um_c4_err", m_err_o, 0);
    tick(); #1;
    check("um_c5_err", m_err_o, 2'b10);
    set_m(1, 0, 0, 0, 32'h0);
    tick();

    // m0 write to slave 4, which never acks
    set_m(0, 1, 1, 1, 32'hA000_0000);
    tick(); #1;
    check("wd_c1_stb", s_stb_o, 6'b010000);
    repeat (15) tick();
    #1;
    check("wd_c16_err", m_err_o, 0);
    check("wd_c16_stb", s_stb_o, 6'b010000);
    tick(); #1;
`ifdef WB_INTERCON_TIMEOUT_EN
    check("wd_c17_err", m_err_o, 2'b01);
    check("wd_c17_stb", s_stb_o, 0);
    check("wd_c17_cyc", s_cyc_o, 0);
    tick(); #1;
    check("wd_c18_err", m_err_o, 0);
    check("wd_c18_stb", s_stb_o, 6'b010000);
`else
    seen_err = 0;
    for (int i = 0; i < 1000; i++) begin
      if (m_err_o != 2'b00) seen_err++;
      tick(); #1;
    end
    check("wd_off_err", 64'(seen_err), 0);
    check("wd_off_stb", s_stb_o, 6'b010000);
`endif
    set_m(0, 0, 0, 0, 32'h0);
    tick(); tick();

    // Reset while m0 is mid-transfer to slave 2 (ptr is 1 beforehand)
    set_m(0, 1, 1, 0, 32'h6000_0000);
    tick(); #1;
    check("mr_c1_gnt", gnt_o, 2'b01);
    check("mr_c1_stb", s_stb_o, 6'b000100);
    tick(); rst = 1'b1;
    tick(); #1;
    check("mr_gnt", gnt_o, 0);
    check("mr_stb", s_stb_o, 0);
    check("mr_cyc", s_cyc_o, 0);
    check("mr_ack", m_ack_o, 0);
    check("mr_err", m_err_o, 0);
    rst = 1'b0;
    set_m(1, 1, 1, 0, 32'h0000_0010);
    tick(); #1;
    check("mr_next_gnt", gnt_o, 2'b01);
    set_m(0, 0, 0, 0, 32'h0);
    set_m(1, 0, 0, 0, 32'h0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
